sub_divider_ctrl: RTL and testbench
===================================

// Module: sub_divider_ctrl
// PURPOSE
//  Sequencing controller for the WIDTH-bit subtractor datapath: unsigned integer division
//  by repeated subtraction of divisor from running remainder, one subtraction per clock.
//  Sits between a command source (start/operands) and a consumer (done/results).
//  Instantiates one subtractor (X - Y -> result) as its only arithmetic resource.
// PARAMETERS
//  WIDTH   8   operand, quotient and remainder width in bits
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  start      in   1      command strobe; accepted only while ready=1
//  dividend   in   WIDTH  unsigned dividend, sampled on accepted start
//  divisor    in   WIDTH  unsigned divisor, sampled on accepted start
//  ready      out  1      1 in IDLE only
//  busy       out  1      1 in RUN only
//  done       out  1      one-cycle pulse in DONE
//  quotient   out  WIDTH  result; valid from DONE cycle until next accepted start
//  remainder  out  WIDTH  result; valid from DONE cycle until next accepted start
//  div_zero   out  1      1 if last accepted command had divisor=0; held like quotient
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; ready=1; busy=0; done=0; quotient=0;
//    remainder=0; div_zero=0; internal divisor register=0. Reset mid-RUN aborts without done.
//  - States: IDLE, RUN, DONE. Outputs registered/state-decoded, no combinational input->output path.
//  - IDLE: start=1 with divisor!=0 -> latch rem=dividend, d=divisor, q=0, div_zero=0; go RUN.
//    start=1 with divisor=0 -> quotient=all ones, remainder=dividend, div_zero=1; go DONE.
//    start=0 -> stay IDLE, outputs hold.
//  - RUN: if rem >= d: rem <= subtractor(rem, d); q <= q+1; stay RUN.
//    else: go DONE (quotient=q, remainder=rem). Compare is unsigned; subtractor used only when rem>=d.
//  - DONE: done=1 for exactly this cycle; unconditionally -> IDLE next edge.
//  - start while not IDLE (RUN or DONE) is ignored, not queued; operands not re-sampled.
//  - Latency: start sampled in cycle 0; RUN spans cycles 1..Q+1; done high in cycle Q+2.
//    Divisor=0: done high in cycle 1. Dividend<divisor: Q=0, done in cycle 2.
//  - Widths: q counts at most 2^WIDTH-1 (divisor>=1), no overflow; rem never wraps.
//  - Invariant at done (divisor!=0): quotient*divisor + remainder == dividend, remainder < divisor.
//  - Operand inputs may change freely after acceptance; results depend only on latched values.
// CONFIGURATION
//  SUB_DIV_CYCLE_COUNT_EN defined: adds output port cycles [WIDTH:0] = number of cycles from
//   accepted start to done (Q+2, or 1 for divide-by-zero); reset 0; updated in DONE cycle, held after.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset: rst_n=0 -> ready=1, busy=0, done=0, quotient=0, remainder=0, div_zero=0.
//  2. 100/7: start cycle 0 -> done only in cycle 16; quotient=14, remainder=2, div_zero=0 (cycles=16).
//  3. 5/9 then 255/1: first -> done cycle 2, q=0, r=5; second -> done cycle 257, q=255, r=0.
//  4. 42/0 -> done cycle 1, quotient=8'hFF, remainder=42, div_zero=1, busy never high (cycles=1).
//  5. 200/3 accepted, start pulsed with 9/9 during RUN and in DONE -> ignored; q=66, r=2; next IDLE start 9/9 -> q=1, r=0.
//  6. 255/1 started, rst_n=0 in cycle 50 -> immediate IDLE, outputs reset, no done; post-reset 10/3 -> q=3, r=1.

Source files
------------

// File: rtl/sub_divider_ctrl.sv
// Unsigned divider controller: repeated subtraction of divisor from remainder, one step per clock.
// Latency: done pulses Q+2 cycles after an accepted start (1 cycle when divisor is 0).
// Backpressure: start is accepted only while ready=1; starts in RUN/DONE are dropped, never queued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               command strobe, sampled with dividend/divisor while ready=1
//   dividend, divisor   WIDTH-bit unsigned operands
//   ready / busy / done IDLE / RUN / one-cycle DONE state decodes
//   quotient, remainder results, valid from the done cycle until the next accepted start
//   div_zero            last accepted command had divisor=0 (quotient forced to all ones)
//   cycles              (only with SUB_DIV_CYCLE_COUNT_EN) cycles from accepted start to done
//
// Optional feature macro: SUB_DIV_CYCLE_COUNT_EN adds the cycles output and its counter.

module sub_divider_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
`ifdef SUB_DIV_CYCLE_COUNT_EN
  ,
  output logic [WIDTH:0]   cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem_r, rem_nxt;
  logic [WIDTH-1:0] d_r, d_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             dz_r, dz_nxt;
  logic [WIDTH-1:0] sub_res;

  // The single arithmetic resource: running remainder minus latched divisor.
  // Its result is only committed when rem_r >= d_r, so the remainder never wraps.
  assign sub_res = rem_r - d_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem_r <= '0;
      d_r   <= '0;
      q_r   <= '0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      rem_r <= rem_nxt;
      d_r   <= d_nxt;
      q_r   <= q_nxt;
      dz_r  <= dz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_r;
    d_nxt     = d_r;
    q_nxt     = q_r;
    dz_nxt    = dz_r;
    case (state)
      IDLE: begin
        if (start) begin
          rem_nxt = dividend;
          d_nxt   = divisor;
          if (divisor == '0) begin
            // Divide by zero skips RUN: results are final immediately.
            q_nxt     = '1;
            dz_nxt    = 1'b1;
            state_nxt = DONE;
          end else begin
            q_nxt     = '0;
            dz_nxt    = 1'b0;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (rem_r >= d_r) begin
          rem_nxt = sub_res;
          q_nxt   = q_r + WIDTH'(1);
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The working registers double as the result registers: they stop changing
  // once RUN exits and hold until the next accepted start.
  assign ready     = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign quotient  = q_r;
  assign remainder = rem_r;
  assign div_zero  = dz_r;

`ifdef SUB_DIV_CYCLE_COUNT_EN
  localparam int CW = WIDTH + 1;

  logic [WIDTH:0] cnt_r;
  logic [WIDTH:0] cycles_r;

  // cnt_r holds the index of the current cycle relative to the start cycle;
  // the value latched on entry to DONE is the index of the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      cycles_r <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt_r <= CW'(1);
      end else if (state == RUN) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (state_nxt == DONE) begin
        cycles_r <= (state == IDLE) ? CW'(1) : cnt_r + CW'(1);
      end
    end
  end

  assign cycles = cycles_r;
`endif

endmodule

// File: tb/tb_sub_divider_ctrl.sv
module tb_sub_divider_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       ready, busy, done, div_zero;
  logic [7:0] quotient, remainder;
`ifdef SUB_DIV_CYCLE_COUNT_EN
  logic [8:0] cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sub_divider_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
`ifdef SUB_DIV_CYCLE_COUNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_flags got ready=%b busy=%b done=%b exp 1/0/0", tag, ready, busy, done);
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL %s_results got q=%0d r=%0d dz=%b exp 0/0/0", tag, quotient, remainder, div_zero);
    end
`ifdef SUB_DIV_CYCLE_COUNT_EN
    checks++;
    if (cycles !== 9'd0) begin
      failures++;
      $display("FAIL %s_cycles got %0d exp 0", tag, cycles);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  // Starts one division at a negedge (cycle 0), then counts cycles until done.
  task automatic run_div(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int ecyc);
    int cyc;
    bit seen_busy;
    seen_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before got %b exp 1", name, ready);
    end
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    // Scramble operands: results must depend only on latched values.
    start = 1'b0; dividend = 8'hA5; divisor = 8'h00;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy === 1'b1) seen_busy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != ecyc) begin
      failures++;
      $display("FAIL %s_done_cycle got %0d (done=%b) exp %0d", name, cyc, done, ecyc);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_zero !== edz) begin
      failures++;
      $display("FAIL %s_result got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
               name, quotient, remainder, div_zero, eq, er, edz);
    end
    checks++;
    if (seen_busy == edz) begin
      failures++;
      $display("FAIL %s_busy_seen got %b exp %b", name, seen_busy, !edz);
    end
`ifdef SUB_DIV_CYCLE_COUNT_EN
    checks++;
    if (cycles !== 9'(ecyc)) begin
      failures++;
      $display("FAIL %s_cycles got %0d exp %0d", name, cycles, ecyc);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || quotient !== eq || remainder !== er) begin
      failures++;
      $display("FAIL %s_after_done got done=%b ready=%b q=%0d r=%0d exp 0/1/%0d/%0d",
               name, done, ready, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_basic();
    run_div("div_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16);
    run_div("div_0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 2);
    run_div("div_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    run_div("div_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 2);
    run_div("div_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 257);
  endtask

  task automatic test_div_zero();
    run_div("div_42_0", 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1);
    run_div("div_after_zero", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 6);
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == 10) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    checks++;
    if (done !== 1'b1 || cyc != 68) begin
      failures++;
      $display("FAIL ignore_done_cycle got %0d (done=%b) exp 68", cyc, done);
    end
    checks++;
    if (quotient !== 8'd66 || remainder !== 8'd2) begin
      failures++;
      $display("FAIL ignore_result got q=%0d r=%0d exp q=66 r=2", quotient, remainder);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || quotient !== 8'd66 || remainder !== 8'd2) begin
      failures++;
      $display("FAIL ignore_in_done got ready=%b busy=%b q=%0d r=%0d exp 1/0/66/2",
               ready, busy, quotient, remainder);
    end
    run_div("div_9_9", 8'd9, 8'd9, 8'd1, 8'd0, 1'b0, 3);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen_done;
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy_before got %b exp 1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 || ready !== 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL midrst_no_done got activity after reset exp idle");
    end
    run_div("div_10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
